dm_cache_ctrl: RTL
==================

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines (one 32-bit word per line; power of two).
REQ-002 Parameter IDX_W, default 4, log2(NUM_LINES).
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU request valid, sampled only in IDLE.
REQ-006 cpu_we  input  1  CPU request type: 0 = read, 1 = write.
REQ-007 cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_rdata  output  32  read data, valid while cpu_ready=1.
REQ-010 cpu_ready  output  1  one-cycle completion pulse.
REQ-011 mem_enable  output  1  memory access strobe, held until mem_ack.
REQ-012 mem_read_write  output  1  memory direction: 0 = read, 1 = write.
REQ-013 mem_addr  output  32  word-aligned memory address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-016 mem_ack  input  1  memory completion, one-cycle pulse.

Function
REQ-017 Address split SHALL be: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2] (26 bits at default).
REQ-018 Per-line storage SHALL be: valid (1b), tag, data (32b).
REQ-019 FSM states SHALL be: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
REQ-020 IDLE: cpu_req=1 SHALL latch cpu_we/cpu_addr/cpu_wdata and move to LOOKUP; cpu inputs are ignored outside IDLE.
REQ-021 LOOKUP: hit = valid[index] AND tag match; read hit -> RESP; read miss -> MEM_RD; any write -> MEM_WR.
REQ-022 Read-hit latency SHALL be 2 cycles: request sampled at edge N, cpu_ready=1 during the cycle following edge N+2.
REQ-023 MEM_RD: mem_enable=1, mem_read_write=0, mem_addr={latched addr[31:2],2'b00}, held stable until mem_ack.
REQ-024 MEM_RD on mem_ack: line SHALL be filled (valid=1, tag, data=mem_rdata), cpu_rdata=mem_rdata, go to RESP.
REQ-025 Write policy SHALL be write-through, no-write-allocate.
REQ-026 MEM_WR: mem_enable=1, mem_read_write=1, mem_wdata=latched wdata, held until mem_ack.
REQ-027 MEM_WR on mem_ack: if the LOOKUP result was a hit, line data SHALL update to wdata; miss SHALL leave the line untouched; go to RESP.
REQ-028 RESP: cpu_ready=1 for exactly one cycle, then IDLE; cpu_rdata is undefined for writes (driven 0).
REQ-029 mem_enable SHALL be 0 in IDLE, LOOKUP and RESP.
REQ-030 mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-031 No timeout: MEM_RD/MEM_WR wait indefinitely for mem_ack.
REQ-032 A new cpu_req in the cycle of cpu_ready is not accepted; it is accepted in the following IDLE cycle.
REQ-033 A conflicting miss SHALL overwrite the resident line (no dirty state exists under write-through).

Reset
REQ-034 reset SHALL force, asynchronously: state=IDLE, all valid bits=0, cpu_ready=0, cpu_rdata=0, mem_enable=0, mem_read_write=0, mem_addr=0, mem_wdata=0.
REQ-035 Tag and data arrays need not be reset.
REQ-036 Reset during MEM_RD/MEM_WR SHALL abandon the access, with no line fill and no cpu_ready pulse.

Structure
REQ-037 A shared package SHALL hold the FSM state encodings and the read/write encoding constants (READ=0, WRITE=1).
REQ-038 The line store (valid/tag/data arrays with async valid clear) SHALL be a single sub-module named dm_line_store; the FSM stays in dm_cache_ctrl.

Verification
REQ-039 Cold read addr 0x0000_0010, mem returns 0xDEAD_BEEF after 3 cycles -> one MEM_RD with mem_addr 0x10, cpu_ready with cpu_rdata 0xDEAD_BEEF.
REQ-040 Repeat read of 0x0000_0010 -> no mem_enable, cpu_ready 2 cycles after accept, cpu_rdata 0xDEAD_BEEF.
REQ-041 Write 0x1234_5678 to 0x10 (hit), then read 0x10 -> MEM_WR seen with mem_wdata 0x1234_5678; the read hits and returns 0x1234_5678.
REQ-042 Write to miss addr 0x0000_0020, then read 0x20 -> the read misses (MEM_RD issued), confirming no-write-allocate.
REQ-043 Conflict: read 0x10, then read 0x50 (same index 4), then read 0x10 -> three MEM_RD accesses.
REQ-044 Assert reset while MEM_RD is waiting -> mem_enable drops immediately, no cpu_ready; the next read of 0x10 misses.

Source files
------------

// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller: FSM state
// encoding and the memory read/write direction constants.
package dm_cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_RESP
  } state_t;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU-side request/response port and memory-side access port of the cache.
// The master modport is the environment (CPU plus backing memory); the
// slave modport is the cache controller itself.
interface dm_cache_ctrl_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  logic        mem_enable;
  logic        mem_read_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_enable, mem_read_write, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_enable, mem_read_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dm_line_store.sv
// Line storage for the direct-mapped cache: one valid bit, tag and 32-bit
// data word per line. Reads are combinational; a fill writes valid/tag/data,
// an update rewrites only the data word of a resident line.
module dm_line_store #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             fill_en,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  // Valid bits: cleared asynchronously by reset, set by a line fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: written on fill, data-only rewrite on write hit
  // NOTE: tag and data arrays carry no reset; every read is qualified by the
  // valid bit, so their power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end else if (upd_en) begin
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// One request at a time: IDLE -> LOOKUP -> (MEM_RD | MEM_WR) -> RESP.
// cpu_ready/cpu_rdata are registered off RESP, giving a clean one-cycle
// pulse in the cycle after RESP; a request is not accepted during it.
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4
) (
  input logic            clk,
  input logic            reset,
  dm_cache_ctrl_if.slave bus
);

  localparam int TAG_W = 30 - IDX_W;

  state_t            state_q, state_d;
  logic              we_q;
  logic [31:2]       addr_q;
  logic [31:0]       wdata_q;
  logic              hit_q;
  logic              cpu_ready_q;
  logic [31:0]       cpu_rdata_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [31:0]       line_data;
  logic              hit;
  logic              accept;
  logic              fill_en;
  logic              upd_en;
  logic              unused_addr_lsb;

  assign idx             = addr_q[IDX_W+1:2];
  assign tag             = addr_q[31:IDX_W+2];
  assign hit             = line_valid && (line_tag == tag);
  assign accept          = (state_q == ST_IDLE) && bus.cpu_req && !cpu_ready_q;
  assign fill_en         = (state_q == ST_MEM_RD) && bus.mem_ack;
  assign upd_en          = (state_q == ST_MEM_WR) && bus.mem_ack && hit_q;
  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  dm_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .fill_en  (fill_en),
    .upd_en   (upd_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (fill_en ? bus.mem_rdata : wdata_q)
  );

  // FSM state register
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture in IDLE and hit capture in LOOKUP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.cpu_we;
        addr_q  <= bus.cpu_addr[31:2];
        wdata_q <= bus.cpu_wdata;
      end
      if (state_q == ST_LOOKUP) begin
        hit_q <= hit;
      end
    end
  end

  // Next-state logic and memory port decode
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    state_d            = state_q;
    bus.mem_enable     = 1'b0;
    bus.mem_read_write = READ;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (we_q == WRITE) state_d = ST_MEM_WR;
        else if (hit)      state_d = ST_RESP;
        else               state_d = ST_MEM_RD;
      end
      ST_MEM_RD: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = {addr_q, 2'b00};
        if (bus.mem_ack) state_d = ST_RESP;
      end
      ST_MEM_WR: begin
        bus.mem_enable     = 1'b1;
        bus.mem_read_write = WRITE;
        bus.mem_addr       = {addr_q, 2'b00};
        bus.mem_wdata      = wdata_q;
        if (bus.mem_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered CPU response: the line already holds the fill or hit data in RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ready_q <= (state_q == ST_RESP);
      cpu_rdata_q <= ((state_q == ST_RESP) && (we_q == READ)) ? line_data : '0;
    end
  end

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;

endmodule
